brake_input_conditioner: RTL and testbench

//   Upstream stage of the brake light controller. Synchronises and debounces the raw

---
 rtl/brake_input_conditioner.sv | 149 ++++++++++++++
 tb/tb_brake_input_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/brake_input_conditioner.sv
// Brake switch front end: two-flop synchroniser, counter debouncer and an
// attention-flash FSM that blinks the brake light before holding it steady.
module brake_input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int FLASH_HALF_CYCLES = 3125000,
  parameter int FLASH_COUNT       = 3
) (
  input  logic c50M,
  input  logic reset,
  input  logic brakeSwitchRaw,
  output logic brakeDebounced,
  output logic brakeActive,
  output logic flashing
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(FLASH_HALF_CYCLES + 1);
  localparam int FW = (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_HALF_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'((FLASH_COUNT > 0) ? FLASH_COUNT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2,
    STEADY    = 2'd3
  } state_t;

  logic          s1_reg;
  logic          s2_reg;
  logic          stable_reg;
  logic [DW-1:0] db_cnt_reg;

  state_t        state_reg;
  state_t        state_next;
  logic [PW-1:0] phase_cnt_reg;
  logic [PW-1:0] phase_cnt_next;
  logic [FW-1:0] flash_cnt_reg;
  logic [FW-1:0] flash_cnt_next;

  // Any disagreement shorter than DEBOUNCE_CYCLES leaves stable_reg untouched.
  always_ff @(posedge c50M or posedge reset) begin
    if (reset) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      stable_reg <= 1'b0;
      db_cnt_reg <= '0;
    end else begin
      s1_reg <= brakeSwitchRaw;
      s2_reg <= s1_reg;
      if (s2_reg == stable_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        stable_reg <= s2_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign brakeDebounced = stable_reg;

  always_ff @(posedge c50M or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      flash_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      flash_cnt_reg <= flash_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    flash_cnt_next = flash_cnt_reg;
    case (state_reg)
      IDLE: begin
        phase_cnt_next = '0;
        flash_cnt_next = '0;
        if (stable_reg) begin
          state_next = (FLASH_COUNT == 0) ? STEADY : FLASH_ON;
        end
      end
      FLASH_ON: begin
        if (phase_cnt_reg == PHASE_LAST) begin
          phase_cnt_next = '0;
          state_next     = FLASH_OFF;
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end
      FLASH_OFF: begin
        if (phase_cnt_reg == PHASE_LAST) begin
          phase_cnt_next = '0;
          if (flash_cnt_reg == FLASH_LAST) begin
            state_next = STEADY;
          end else begin
            flash_cnt_next = flash_cnt_reg + 1'b1;
            state_next     = FLASH_ON;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end
      STEADY: begin
        state_next = STEADY;
      end
      default: begin
        state_next     = IDLE;
        phase_cnt_next = '0;
        flash_cnt_next = '0;
      end
    endcase
    // Release wins over any phase expiry so a re-press always starts a fresh sequence.
    if (!stable_reg) begin
      state_next     = IDLE;
      phase_cnt_next = '0;
      flash_cnt_next = '0;
    end
  end

  always_comb begin
    brakeActive = 1'b0;
    flashing    = 1'b0;
    case (state_reg)
      FLASH_ON: begin
        brakeActive = 1'b1;
        flashing    = 1'b1;
      end
      FLASH_OFF: begin
        flashing = 1'b1;
      end
      STEADY: begin
        brakeActive = 1'b1;
      end
      default: begin
        brakeActive = 1'b0;
        flashing    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_brake_input_conditioner.sv
// Bench for brake_input_conditioner: per-cycle scoreboard fed by a run-length /
// elapsed-time reference model, plus directed checks of the documented timelines.
module tb_brake_input_conditioner;

  localparam int DB = 4;
  localparam int H  = 8;
  localparam int FC = 2;

  logic clk;
  logic reset;
  logic raw;
  logic deb0, act0, fl0;
  logic deb1, act1, fl1;

  int n_checks = 0;
  int n_fail   = 0;

  brake_input_conditioner #(
    .DEBOUNCE_CYCLES(DB), .FLASH_HALF_CYCLES(H), .FLASH_COUNT(FC)
  ) dut (
    .c50M(clk), .reset(reset), .brakeSwitchRaw(raw),
    .brakeDebounced(deb0), .brakeActive(act0), .flashing(fl0)
  );

  brake_input_conditioner #(
    .DEBOUNCE_CYCLES(DB), .FLASH_HALF_CYCLES(H), .FLASH_COUNT(0)
  ) dut_nf (
    .c50M(clk), .reset(reset), .brakeSwitchRaw(raw),
    .brakeDebounced(deb1), .brakeActive(act1), .flashing(fl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, want);
    end
  endtask

  // Expected {brakeActive, flashing} from elapsed time since the debounced press.
  function automatic logic [1:0] fsm_expect(input int fc, input bit deb_prev, input int t);
    if (!deb_prev) return 2'b00;
    if (fc == 0) return 2'b10;
    if (t < 2 * H * fc) return {((t / H) % 2) == 0, 1'b1};
    return 2'b10;
  endfunction

  // Scoreboard entry: {deb, act0, fl0, act1, fl1}
  logic [4:0] exp_q[$];

  // Reference model: raw sampled each edge reaches the debouncer two edges later;
  // the debounced value follows a run of DB identical samples.
  initial begin : model
    int  m_e;
    int  run_len;
    int  m_rise;
    bit  run_val, m_deb, s_used;
    bit  samp[$];
    logic [1:0] o0, o1;
    m_e = 0; run_len = DB; run_val = 0; m_deb = 0; m_rise = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_e = 0; run_len = DB; run_val = 0; m_deb = 0; m_rise = 0;
        samp.delete();
        exp_q.delete();
        exp_q.push_back(5'b0);
      end else begin
        m_e++;
        s_used = (samp.size() >= 2) ? samp[samp.size()-2] : 1'b0;
        samp.push_back(raw);
        if (samp.size() > 4) void'(samp.pop_front());
        o0 = fsm_expect(FC, m_deb, m_e - m_rise - 1);
        o1 = fsm_expect(0,  m_deb, m_e - m_rise - 1);
        if (s_used == run_val) begin
          if (run_len < 1000) run_len++;
        end else begin
          run_val = s_used;
          run_len = 1;
        end
        if (run_val != m_deb && run_len >= DB) begin
          m_deb = run_val;
          if (m_deb) m_rise = m_e;
        end
        exp_q.push_back({m_deb, o0, o1});
      end
    end
  end

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_deb",  deb0, e[4]);
        chk("sb_deb_nf", deb1, e[4]);
        chk("sb_out",  {act0, fl0}, e[3:2]);
        chk("sb_out_nf", {act1, fl1}, e[1:0]);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  // Edge 0 is the posedge after which raw goes high; checks k = 1..45 of the timeline.
  task automatic press_timeline(input string nm);
    int want_act;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      want_act = ((k >= 7 && k <= 14) || (k >= 23 && k <= 30) || k >= 39) ? 1 : 0;
      chk({nm, "_deb"}, deb0, (k >= 6) ? 1 : 0);
      chk({nm, "_act"}, act0, want_act);
      chk({nm, "_flash"}, fl0, (k >= 7 && k <= 38) ? 1 : 0);
      chk({nm, "_nf_act"}, {act1, fl1}, (k >= 7) ? 2 : 0);
    end
  endtask

  task automatic idle(input int n);
    raw = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int saw;
    int hold;
    reset = 1'b1;
    raw   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {deb0, act0, fl0, deb1, act1, fl1}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(8);

    $display("scenario clean press + steady release");
    @(posedge clk); #1;
    raw = 1'b1;
    press_timeline("press");
    for (int k = 46; k <= 107; k++) begin
      @(posedge clk); #1;
      if (k == 105) chk("rel_deb105", deb0, 1);
      if (k == 106) chk("rel_deb106", {deb0, act0}, 2'b01);
      if (k == 107) chk("rel_act107", {act0, fl0, act1}, 0);
      if (k == 100) raw = 1'b0;
    end
    idle(10);

    $display("scenario release mid-flash then re-press");
    @(posedge clk); #1;
    raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 23) chk("mid_deb23", deb0, 1);
      if (k == 24) chk("mid_deb24", deb0, 0);
      if (k == 25) chk("mid_out25", {act0, fl0}, 0);
      if (k == 18) raw = 1'b0;
    end
    idle(10);
    @(posedge clk); #1;
    raw = 1'b1;
    press_timeline("repress");
    idle(12);

    $display("scenario bounce 3/3 for 60 cycles");
    saw = 0;
    for (int k = 0; k < 60; k++) begin
      raw = ((k / 3) % 2) == 0;
      @(posedge clk); #1;
      if (deb0 || act0 || act1) saw = 1;
    end
    chk("bounce_quiet", saw, 0);
    idle(12);

    $display("scenario async reset mid flash");
    @(posedge clk); #1;
    raw = 1'b1;
    repeat (11) @(posedge clk);
    #3;
    chk("pre_reset_on", {act0, fl0}, 2'b11);
    reset = 1'b1;
    #1;
    chk("async_reset", {deb0, act0, fl0, deb1, act1, fl1}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    press_timeline("after_reset");
    idle(12);

    $display("scenario randomized raw stream");
    for (int i = 0; i < 250; i++) begin
      raw  = 1'($urandom_range(0, 1));
      hold = (($urandom & 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 7));
      repeat (hold) @(posedge clk);
      #1;
    end
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
